// File: rtl/pc_unit_if.sv
// Bus between the instruction decoder / ALU flags and the fetch-side program counter.
// Handshake: en qualifies every control input for one cycle; there is no backpressure and pc/sp_depth/flags are always valid.
interface pc_unit_if #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              en;
  logic              is_jump;
  logic [1:0]        jump_cond;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] target;
  logic              flag_z;
  logic              flag_cy;
  logic              flag_ov;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  sp_depth;
  logic              stack_ovf;
  logic              stack_unf;

  modport master (
    output en, is_jump, jump_cond, call, ret, target, flag_z, flag_cy, flag_ov,
    input  pc, sp_depth, stack_ovf, stack_unf
  );

  modport slave (
    input  en, is_jump, jump_cond, call, ret, target, flag_z, flag_cy, flag_ov,
    output pc, sp_depth, stack_ovf, stack_unf
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with conditional jumps and a circular hardware return stack
// carrying sticky overflow/underflow flags.
module pc_unit #(
  parameter int          ADDR_W    = 10,
  parameter int          DEPTH     = 8,
  parameter int unsigned RESET_VEC = 0
) (
  input logic      clk,
  input logic      rst,
  pc_unit_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [CNT_W-1:0]  depth_q, depth_d;
  logic [PTR_W-1:0]  top_q, top_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push;
  logic              cond_true;
  logic [ADDR_W-1:0] stack_q [DEPTH];

  always_comb begin
    unique case (bus.jump_cond)
      2'b00:   cond_true = 1'b1;
      2'b01:   cond_true = bus.flag_z;
      2'b10:   cond_true = bus.flag_cy;
      default: cond_true = bus.flag_ov;
    endcase
  end

  always_comb begin
    pc_inc  = pc_q + ADDR_W'(1);
    pc_d    = pc_q;
    depth_d = depth_q;
    top_d   = top_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (bus.en) begin
      if (bus.call && bus.ret) begin
        pc_d = pc_inc;
      end else if (bus.ret) begin
        if (depth_q != '0) begin
          pc_d    = stack_q[top_q];
          top_d   = top_q - PTR_W'(1);
          depth_d = depth_q - CNT_W'(1);
        end else begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end
      end else if (bus.call) begin
        // When full, top+1 lands on the oldest entry, so it is overwritten in place.
        push  = 1'b1;
        top_d = top_q + PTR_W'(1);
        pc_d  = bus.target;
        if (depth_q == CNT_W'(DEPTH)) ovf_d = 1'b1;
        else                          depth_d = depth_q + CNT_W'(1);
      end else if (bus.is_jump && cond_true) begin
        pc_d = bus.target;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= ADDR_W'(RESET_VEC);
      depth_q <= '0;
      top_q   <= '1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) stack_q[top_d] <= pc_inc;
  end

  assign bus.pc        = pc_q;
  assign bus.sp_depth  = depth_q;
  assign bus.stack_ovf = ovf_q;
  assign bus.stack_unf = unf_q;
endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a queue-based return-stack model predicts pc, depth and
// sticky flags for every cycle; a negedge monitor pops and compares.
module tb_pc_unit;
  localparam int ADDR_W  = 10;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int W       = ADDR_W + CNT_W + 2;
  localparam int AW_SIZE = 1 << ADDR_W;
  localparam int RST_PC  = 0;

  logic clk;
  logic rst;

  pc_unit_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  pc_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_VEC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model state
  int   m_pc;
  int   m_stk[$];
  logic m_ovf;
  logic m_unf;

  logic [W-1:0] exp_q[$];
  int checks;
  int errors;

  initial begin
    m_pc   = RST_PC;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    checks = 0;
    errors = 0;
  end

  task automatic model_step(input logic r, e, j, input logic [1:0] c, input logic ca, re,
                            input int t, input logic z, cy, ov);
    logic taken;
    if (r) begin
      m_pc = RST_PC;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (e) begin
      taken = (c == 2'd0) || (c == 2'd1 && z) || (c == 2'd2 && cy) || (c == 2'd3 && ov);
      if (ca && re) m_pc = (m_pc + 1) % AW_SIZE;
      else if (re) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin
          m_pc  = (m_pc + 1) % AW_SIZE;
          m_unf = 1'b1;
        end
      end else if (ca) begin
        m_stk.push_back((m_pc + 1) % AW_SIZE);
        if (m_stk.size() > DEPTH) begin
          void'(m_stk.pop_front());
          m_ovf = 1'b1;
        end
        m_pc = t;
      end else if (j && taken) m_pc = t;
      else m_pc = (m_pc + 1) % AW_SIZE;
    end
    exp_q.push_back({ADDR_W'(m_pc), CNT_W'(m_stk.size()), m_ovf, m_unf});
  endtask

  // driver
  task automatic drive(input logic r, e, j, input logic [1:0] c, input logic ca, re,
                       input int t, input logic z, cy, ov);
    rst           = r;
    bus.en        = e;
    bus.is_jump   = j;
    bus.jump_cond = c;
    bus.call      = ca;
    bus.ret       = re;
    bus.target    = ADDR_W'(t);
    bus.flag_z    = z;
    bus.flag_cy   = cy;
    bus.flag_ov   = ov;
    model_step(r, e, j, c, ca, re, t, z, cy, ov);
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();            drive(1, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0); endtask
  task automatic idle();              drive(0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0); endtask
  task automatic stall();             drive(0, 0, 1, 2'd0, 1, 0, 77, 1, 1, 1); endtask
  task automatic jmp_to(input int t); drive(0, 1, 1, 2'd0, 0, 0, t, 0, 0, 0); endtask
  task automatic do_call(input int t); drive(0, 1, 0, 2'd3, 1, 0, t, 0, 0, 0); endtask
  task automatic do_ret();            drive(0, 1, 0, 2'd0, 0, 1, 0, 0, 0, 0); endtask

  // monitor
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {bus.pc, bus.sp_depth, bus.stack_ovf, bus.stack_unf};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL state t=%0t: got pc=%0d depth=%0d ovf=%b unf=%b, expected pc=%0d depth=%0d ovf=%b unf=%b",
                 $time, got[W-1 -: ADDR_W], got[CNT_W+1:2], got[1], got[0],
                 exp[W-1 -: ADDR_W], exp[CNT_W+1:2], exp[1], exp[0]);
      end
    end
  end

  // stimulus
  initial begin
    do_rst();
    repeat (5) idle();
    stall();
    stall();
    do_rst();

    // conditional jumps from pc=5 to 300
    jmp_to(5); drive(0, 1, 1, 2'd1, 0, 0, 300, 0, 0, 0);
    jmp_to(5); drive(0, 1, 1, 2'd1, 0, 0, 300, 1, 0, 0);
    jmp_to(5); drive(0, 1, 1, 2'd2, 0, 0, 300, 0, 1, 0);
    jmp_to(5); drive(0, 1, 1, 2'd3, 0, 0, 300, 1, 1, 0);
    jmp_to(5); drive(0, 1, 1, 2'd0, 0, 0, 300, 0, 0, 0);

    // nested call/ret
    jmp_to(10); do_call(100); do_call(200); do_ret(); do_ret();

    // overflow then underflow
    do_rst();
    for (int i = 1; i <= 5; i++) do_call(i);
    repeat (5) do_ret();

    // wrap and illegal call&ret
    jmp_to(1023); idle();
    jmp_to(1023); do_call(50); do_ret();
    jmp_to(7); drive(0, 1, 0, 2'd0, 1, 1, 99, 0, 0, 0);

    // reset mid-stack together with ret
    do_rst();
    for (int i = 0; i < 5; i++) do_call(20 + i);
    do_ret();
    drive(1, 1, 0, 2'd0, 0, 1, 0, 0, 0, 0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic r, e, j, ca, re;
      r  = ($urandom_range(0, 99) < 2);
      e  = ($urandom_range(0, 99) < 85);
      j  = ($urandom_range(0, 99) < 30);
      ca = ($urandom_range(0, 99) < 20);
      re = ($urandom_range(0, 99) < 20);
      drive(r, e, j, 2'($urandom_range(0, 3)), ca, re, int'($urandom_range(0, AW_SIZE - 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Fetch-side program counter for the 16-bit accumulator CPU. It sits directly upstream of the instruction decoder.
- The registered `pc` addresses the combinational instruction ROM, which feeds the decoder.
- The decoder's jump/call/ret controls, the operand target and the current ALU flags come back here to select the next PC.
- Holds a hardware return stack for `CALL`/`RET`, with sticky overflow/underflow error flags.

Parameters:
- ADDR_W, 10, PC/target width (program memory of 2^ADDR_W words)
- DEPTH, 8, return-stack entries (power of two, >=2)
- RESET_VEC, 0, PC value after reset

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- en  input  1  advance enable; 0 = stall (all state held)
- is_jump  input  1  decoded jump/call/ret
- jump_cond  input  2  00 JMP (always), 01 JZ (flag_z), 10 JC (flag_cy), 11 JO (flag_ov)
- call  input  1  push return address, jump to target
- ret  input  1  pop return address into PC
- target  input  ADDR_W  jump/call destination (decoder operand[ADDR_W-1:0])
- flag_z  input  1  registered zero flag
- flag_cy  input  1  registered carry flag
- flag_ov  input  1  registered overflow flag
- pc  output  ADDR_W  current instruction address (registered)
- sp_depth  output  $clog2(DEPTH)+1  valid entries on return stack
- stack_ovf  output  1  sticky: push occurred while full
- stack_unf  output  1  sticky: pop occurred while empty

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: `pc`=RESET_VEC, `sp_depth`=0, `stack_ovf`=0, `stack_unf`=0. Stack contents are don't-care. Reset overrides `en` and all controls, including mid-call/mid-ret.
- Timing: `pc` is a register. ROM, decoder and next-PC logic are combinational in the same cycle, so each instruction executes in 1 cycle and the new PC is visible the cycle after the edge.
- Stall: `en`=0 means no change to any register, regardless of other inputs.
- With `en`=1, the next-PC priority is:
  1. `call`&`ret` both 1 (illegal): `pc`<=pc+1, no stack op, no flag change.
  2. `ret`: if `sp_depth`>0, `pc`<=top entry and `sp_depth`-=1. If empty, `pc`<=pc+1 and `stack_unf`<=1.
  3. `call`: push pc+1 (mod 2^ADDR_W) and `pc`<=`target`.
  4. `is_jump` & cond_true: `pc`<=`target`.
  5. Otherwise: `pc`<=pc+1.
- cond_true is 1 for JMP, `flag_z` for JZ, `flag_cy` for JC, `flag_ov` for JO.
- `call`/`ret` are honoured even if `is_jump`=0; `jump_cond` is ignored for them.
- Stack structure: circular buffer of DEPTH entries with a top pointer plus `sp_depth` counter (0..DEPTH).
- Push while full (`sp_depth`=DEPTH): the oldest entry is overwritten, `sp_depth` stays DEPTH, `stack_ovf`<=1. The call still jumps. The most recent DEPTH returns remain correct.
- Wrap-around: PC increment and the return address wrap modulo 2^ADDR_W (e.g. 1023+1 -> 0 for ADDR_W=10). No error is raised.
- Sticky flags: `stack_ovf`/`stack_unf` clear only on `rst`.
- `target` bits above ADDR_W do not exist. The integrator truncates the decoder operand.
- No combinational path from inputs to `pc`.

Test Plan:
- Reset and increment: rst=1 for 1 cycle, then en=1 with no controls for 5 cycles -> pc 0,1,2,3,4,5. Hold en=0 for 2 cycles -> pc holds 5. Set rst=1 -> pc=0 next cycle.
- Conditional jumps at pc=5, target=300:
  - JZ, flag_z=0 -> pc=6.
  - JZ, flag_z=1 -> pc=300.
  - JC, flag_cy=1 -> pc=300.
  - JO, flag_ov=0 -> pc+1.
  - JMP with all flags 0 -> pc=300.
- Nested call/ret: pc=10 call 100 -> pc=100, depth=1. Call 200 -> pc=200, depth=2. Ret -> pc=101. Ret -> pc=11, depth=0. No error flags set.
- Overflow with DEPTH=4: 5 nested calls from pc=0,1,2,3,4 (each target = next caller) -> stack_ovf=1, depth=4. Then 4 rets return to 5,4,3,2 in that order. A 5th ret -> stack_unf=1, pc=2+1=3.
- Wrap and illegal: pc=1023, no control -> pc=0. pc=1023 call 50 -> later ret -> pc=0. call&ret both 1 at pc=7 -> pc=8, depth and flags unchanged.
- Reset mid-stack: depth=3 with ovf=1, assert rst together with ret=1 -> pc=RESET_VEC, depth=0, ovf=0, unf=0.
